// File: rtl/count_ones_pipe_pkg.sv
// Shared constants and elaboration-time helpers for the pipelined population counter.
package count_ones_pipe_pkg;

  localparam int TMDB_CELLS    = 48;
  localparam int DEFAULT_CHUNK = 8;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Number of tree nodes alive at a given level (ceil(n / 2^lvl)).
  function automatic int nodes(input int n, input int lvl);
    return (n + (1 << lvl) - 1) >> lvl;
  endfunction

  function automatic int lvl_w(input int cw, input int lvl, input int out_w);
    return (cw + lvl < out_w) ? cw + lvl : out_w;
  endfunction

endpackage

// File: rtl/popcount_chunk.sv
// Combinational ones count over one CHUNK-bit slice of the hit vector.
module popcount_chunk
  import count_ones_pipe_pkg::*;
#(
  parameter int CHUNK = DEFAULT_CHUNK
) (
  input  logic [CHUNK-1:0]             bits_i,
  output logic [clog2(CHUNK+1)-1:0]    cnt_o
);

  localparam int CW = clog2(CHUNK + 1);

  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < CHUNK; i++) cnt_o = cnt_o + CW'(bits_i[i]);
  end

endmodule

// File: rtl/count_ones_pipe.sv
// Pipelined popcount: registered chunk counters, a registered pairwise adder tree,
// and an output stage with threshold flag and clearable peak hold.
module count_ones_pipe
  import count_ones_pipe_pkg::*;
#(
  parameter int WIDTH = TMDB_CELLS,
  parameter int CHUNK = DEFAULT_CHUNK
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  input  logic [WIDTH-1:0]            in_data,
  input  logic [clog2(WIDTH+1)-1:0]   threshold,
  input  logic                        peak_clr,
  output logic                        out_valid,
  output logic [clog2(WIDTH+1)-1:0]   out_count,
  output logic                        out_ge_thr,
  output logic [clog2(WIDTH+1)-1:0]   peak_count
);

  localparam int NCHUNK  = (WIDTH + CHUNK - 1) / CHUNK;
  localparam int OUT_W   = clog2(WIDTH + 1);
  localparam int LEVELS  = clog2(NCHUNK);
  localparam int LATENCY = LEVELS + 2;
  localparam int CW      = clog2(CHUNK + 1);
  localparam int PADW    = NCHUNK * CHUNK;

  logic [PADW-1:0] pad;
  assign pad = PADW'(in_data);

  for (genvar c = 0; c < NCHUNK; c++) begin : g_chunk
    logic [CW-1:0] cnt;
    popcount_chunk #(.CHUNK(CHUNK)) u_cnt (
      .bits_i (pad[c*CHUNK +: CHUNK]),
      .cnt_o  (cnt)
    );
  end

  // Level 0 holds the registered chunk counts; each later level halves the node count.
  // Odd tail nodes are registered pass-throughs so all paths share one latency.
  for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
    localparam int N  = nodes(NCHUNK, l);
    localparam int LW = lvl_w(CW, l, OUT_W);
    for (genvar k = 0; k < N; k++) begin : g_node
      logic [LW-1:0] sum_d, sum_q;
      if (l == 0) begin : g_leaf
        assign sum_d = LW'(g_chunk[k].cnt);
      end else begin : g_tree
        if (2*k + 1 < nodes(NCHUNK, l - 1)) begin : g_add
          assign sum_d = LW'(g_lvl[l-1].g_node[2*k].sum_q)
                       + LW'(g_lvl[l-1].g_node[2*k+1].sum_q);
        end else begin : g_pass
          assign sum_d = LW'(g_lvl[l-1].g_node[2*k].sum_q);
        end
      end
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sum_q <= '0;
        else        sum_q <= sum_d;
      end
    end
  end

  logic [LATENCY:1] vld_pipe_q;
  logic [OUT_W-1:0] root, cnt_q, peak_d, peak_q;
  logic             v_in, ge_q;

  assign root = OUT_W'(g_lvl[LEVELS].g_node[0].sum_q);
  assign v_in = vld_pipe_q[LATENCY-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_pipe_q <= '0;
    else        vld_pipe_q <= {vld_pipe_q[LATENCY-1:1], in_valid};
  end

  // A clear coinciding with a valid result keeps that result rather than zero.
  always_comb begin
    peak_d = peak_q;
    if (peak_clr)                     peak_d = v_in ? root : '0;
    else if (v_in && (root > peak_q)) peak_d = root;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      ge_q   <= 1'b0;
      peak_q <= '0;
    end else begin
      cnt_q  <= root;
      ge_q   <= v_in && (root >= threshold);
      peak_q <= peak_d;
    end
  end

  assign out_valid  = vld_pipe_q[LATENCY];
  assign out_count  = cnt_q;
  assign out_ge_thr = ge_q;
  assign peak_count = peak_q;

endmodule
